conv_encoder_stream: RTL
========================

// Module: conv_encoder_stream
// PURPOSE
//  Rate-1/2 feed-forward convolutional encoder that produces the 2-bit symbol
//  frames consumed by viterbi_universal. Accepts a frame of info bits over a
//  valid/ready stream and emits one symbol per bit, with an optional zero tail.
//  Used as the TX-side source in loopback benches and on-chip BIST.
// PARAMETERS
//  K     7           constraint length; legal range 3..9; state width K-1
//  G0    7'b1111001  generator 0 (171 oct); bit 0 taps the newest input bit
//  G1    7'b1011011  generator 1 (133 oct); bit 0 taps the newest input bit
//  TAIL  1           1: append K-1 zero flush bits after data; 0: no tail
// PORTS
//  clk        in   1   clock; all state updates on rising edge
//  rst_n      in   1   asynchronous active-low reset
//  start      in   1   begin frame; sampled only in IDLE
//  frame_len  in   8   info-bit count; latched on accepted start
//  in_valid   in   1   in_bit is valid
//  in_ready   out  1   encoder accepts in_bit this cycle
//  in_bit     in   1   information bit
//  sym_valid  out  1   sym_out is valid
//  sym_ready  in   1   downstream accepts sym_out this cycle
//  sym_out    out  2   {^(r&G0), ^(r&G1)}, where r = {sr[K-2:0], bit}
//  sym_last   out  1   sym_out is the final symbol of the frame
//  busy       out  1   state != IDLE
//  done       out  1   one-cycle pulse after the last symbol is accepted
//  sym_count  out  9   symbols accepted downstream in the current frame
// BEHAVIOUR
//  Reset: state=IDLE. sr, sym_out, sym_count = 0. sym_valid, sym_last,
//   in_ready, busy and done are all 0.
//  FSM states: IDLE -> DATA -> TAIL -> FLUSH -> IDLE.
//   IDLE:  when start=1, latch frame_len, clear sr and sym_count, then go to
//          DATA. If frame_len=0, go to TAIL (TAIL=1) or FLUSH (TAIL=0).
//   DATA:  in_ready = !sym_valid || sym_ready. A bit is accepted when
//          in_valid && in_ready. On accept:
//          r = {sr[K-2:0], in_bit}; sym_out <= {^(r&G0), ^(r&G1)};
//          sym_valid <= 1; sr <= r[K-2:0].
//          After frame_len accepts, go to TAIL (TAIL=1) or FLUSH (TAIL=0).
//   TAIL:  in_ready = 0. Encode K-1 internal zero bits using the same
//          advance rule (advance when !sym_valid || sym_ready). Then go to FLUSH.
//   FLUSH: wait until the last symbol is accepted. Then pulse done, go to IDLE.
//  Output register: sym_out/sym_valid hold stable while sym_valid && !sym_ready.
//   sym_valid drops the cycle after acceptance unless a new symbol loads that
//   same cycle.
//  Throughput and latency: 1 symbol/cycle under continuous valid/ready.
//   Latency is 1 cycle from bit accept to sym_valid.
//  sym_last=1 exactly on symbol number frame_len+(TAIL?K-1:0).
//  sym_count increments on each sym_valid && sym_ready.
//   Total symbols = frame_len + TAIL*(K-1); max 255+8 = 263, fits in 9 bits.
//  Combinational paths: in_ready depends on sym_ready (combinational path);
//   no path from in_valid to in_ready.
//  start outside IDLE: ignored. frame_len changes after latch: ignored.
//  in_valid outside DATA: ignored; no bit is consumed.
//  rst_n low mid-frame: abort immediately to the reset state. No done pulse.
//  Pending symbol is discarded.
//  sym_count and sym_last hold after done until the next accepted start.
// TESTING
//  1 K=7, TAIL=0, 32 bits, single '1' at bit 20, sym_ready=1:
//    syms 0..19 = 00; sym20 = 11; sym21 = 01 (G0[1]=0, G1[1]=1);
//    syms 27..31 = 00; sym_last on sym31; done 1 cycle later.
//  2 K=6 (G0=6'b111111, G1=6'b101011), TAIL=1, impulse at bit 16 of 32:
//    37 symbols; syms 32..36 = 00; sym_count = 37.
//  3 Random sym_ready (50%), random in_valid, 200-bit random frame:
//    symbol stream matches golden model; sym_out never changes while stalled.
//  4 frame_len=0, TAIL=1, K=7: exactly 6 symbols of 00 then done.
//    With TAIL=0: no symbols; done 1 cycle after start.
//  5 start pulsed mid-frame: ignored. rst_n low at symbol 10:
//    all outputs reset that cycle; new frame encodes from sr=0.
//  6 Loopback into viterbi_universal, K=7, 64 random bits, no errors:
//    decoded bits equal input bits.

Source files
------------

// File: rtl/conv_encoder_stream.sv
// Rate-1/2 feed-forward convolutional encoder with a valid/ready bit input,
// a registered 2-bit symbol output and an optional K-1 zero-bit tail.
module conv_encoder_stream #(
  parameter int             K    = 7,
  parameter logic [K-1:0]   G0   = 7'b1111001,
  parameter logic [K-1:0]   G1   = 7'b1011011,
  parameter bit             TAIL = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] frame_len,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_bit,
  output logic       sym_valid,
  input  logic       sym_ready,
  output logic [1:0] sym_out,
  output logic       sym_last,
  output logic       busy,
  output logic       done,
  output logic [8:0] sym_count
);

  localparam int         SW       = K - 1;
  localparam logic [3:0] TAIL_LEN = 4'(K - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DATA  = 2'd1,
    ST_TAIL  = 2'd2,
    ST_FLUSH = 2'd3
  } state_t;

  state_t          state_r, state_next_s;
  logic [7:0]      len_r;
  logic [7:0]      bit_cnt_r;
  logic [3:0]      tail_cnt_r;
  logic [SW-1:0]   sr_r;
  logic [1:0]      sym_out_r;
  logic            sym_valid_r;
  logic            sym_last_r;
  logic            done_r;
  logic [8:0]      sym_count_r;

  logic            adv_s, accept_s, tail_step_s, load_s;
  logic            start_ok_s, flush_done_s, last_data_s, last_tail_s;
  logic            enc_bit_s, in_ready_s, busy_s;
  logic [K-1:0]    r_s;

  // Both output bits are parities of the tapped window.
  function automatic logic [1:0] encode_sym(input logic [K-1:0] r);
    return {^(r & G0), ^(r & G1)};
  endfunction

  // Handshake qualifiers shared by the FSM and the datapath.
  always_comb begin
    adv_s        = !sym_valid_r || sym_ready;
    accept_s     = (state_r == ST_DATA) && in_valid && adv_s;
    tail_step_s  = (state_r == ST_TAIL) && adv_s;
    load_s       = accept_s || tail_step_s;
    start_ok_s   = (state_r == ST_IDLE) && start;
    flush_done_s = (state_r == ST_FLUSH) && adv_s;
    last_data_s  = (bit_cnt_r == (len_r - 8'd1));
    last_tail_s  = (tail_cnt_r == (TAIL_LEN - 4'd1));
    if (accept_s) begin
      enc_bit_s = in_bit;
    end else begin
      enc_bit_s = 1'b0;
    end
    r_s = {sr_r, enc_bit_s};
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          if (frame_len != 8'd0) begin
            state_next_s = ST_DATA;
          end else if (TAIL) begin
            state_next_s = ST_TAIL;
          end else begin
            state_next_s = ST_FLUSH;
          end
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_DATA: begin
        if (accept_s && last_data_s) begin
          state_next_s = TAIL ? ST_TAIL : ST_FLUSH;
        end else begin
          state_next_s = ST_DATA;
        end
      end
      ST_TAIL: begin
        if (tail_step_s && last_tail_s) begin
          state_next_s = ST_FLUSH;
        end else begin
          state_next_s = ST_TAIL;
        end
      end
      ST_FLUSH: begin
        if (flush_done_s) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_FLUSH;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // State-decoded outputs; in_ready follows sym_ready combinationally.
  always_comb begin
    in_ready_s = 1'b0;
    busy_s     = 1'b1;
    case (state_r)
      ST_IDLE:  busy_s     = 1'b0;
      ST_DATA:  in_ready_s = adv_s;
      ST_TAIL:  in_ready_s = 1'b0;
      ST_FLUSH: in_ready_s = 1'b0;
      default: begin
        in_ready_s = 1'b0;
        busy_s     = 1'b0;
      end
    endcase
  end

  // Frame bookkeeping: latched length, bit/tail counters, shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_r      <= 8'd0;
      bit_cnt_r  <= 8'd0;
      tail_cnt_r <= 4'd0;
      sr_r       <= '0;
    end else if (start_ok_s) begin
      len_r      <= frame_len;
      bit_cnt_r  <= 8'd0;
      tail_cnt_r <= 4'd0;
      sr_r       <= '0;
    end else begin
      if (accept_s) begin
        bit_cnt_r <= bit_cnt_r + 8'd1;
      end
      if (tail_step_s) begin
        tail_cnt_r <= tail_cnt_r + 4'd1;
      end
      if (load_s) begin
        sr_r <= r_s[SW-1:0];
      end
    end
  end

  // Symbol output register; holds while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sym_out_r   <= 2'b00;
      sym_valid_r <= 1'b0;
      sym_last_r  <= 1'b0;
    end else begin
      if (load_s) begin
        sym_out_r   <= encode_sym(r_s);
        sym_valid_r <= 1'b1;
        sym_last_r  <= accept_s ? (last_data_s && !TAIL) : last_tail_s;
      end else begin
        if (sym_ready) begin
          sym_valid_r <= 1'b0;
        end
        if (start_ok_s) begin
          sym_last_r <= 1'b0;
        end
      end
    end
  end

  // Accepted-symbol counter and end-of-frame pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sym_count_r <= 9'd0;
      done_r      <= 1'b0;
    end else begin
      done_r <= flush_done_s;
      if (start_ok_s) begin
        sym_count_r <= 9'd0;
      end else if (sym_valid_r && sym_ready) begin
        sym_count_r <= sym_count_r + 9'd1;
      end
    end
  end

  assign in_ready  = in_ready_s;
  assign busy      = busy_s;
  assign sym_out   = sym_out_r;
  assign sym_valid = sym_valid_r;
  assign sym_last  = sym_last_r;
  assign done      = done_r;
  assign sym_count = sym_count_r;

endmodule
